// File: rtl/tube_display.sv
// 8-digit multiplexed hex display with CPU-writable 32-bit value and per-digit blank mask.
// seg_out/seg_en are registered one cycle after the scan/value/mask state; writes never stall.
module tube_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tubecs,
  input  logic        tubewrite,
  input  logic [1:0]  tubeaddr,
  input  logic [15:0] tubewdata,
  output logic [7:0]  seg_out,
  output logic [7:0]  seg_en,
  output logic [31:0] tube_value
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  logic [31:0] value_q;
  logic [7:0]  mask_q;
  logic [15:0] scan_cnt;
  logic [2:0]  digit_idx;
  logic        wr_vld;
  logic        scan_wrap;
  logic [3:0]  nibble;
  logic [7:0]  seg_nxt;
  logic [7:0]  en_nxt;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
    logic [7:0] s;
    case (h)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign wr_vld     = tubecs & tubewrite;
  assign scan_wrap  = (scan_cnt == SCAN_LAST);
  assign nibble     = value_q[{digit_idx, 2'b00} +: 4];
  assign tube_value = value_q;

  // Blanked digits drive no enable at all, so at most one enable is ever low.
  always_comb begin
    seg_nxt = 8'hFF;
    en_nxt  = 8'hFF;
    if (!mask_q[digit_idx]) begin
      seg_nxt = hex_to_seg(nibble);
      en_nxt  = ~(8'h01 << digit_idx);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= 32'h0;
      mask_q  <= 8'h00;
    end else if (wr_vld) begin
      case (tubeaddr)
        2'b00:   value_q[15:0]  <= tubewdata;
        2'b01:   value_q[31:16] <= tubewdata;
        2'b10:   mask_q         <= tubewdata[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= 16'h0;
      digit_idx <= 3'd0;
    end else if (scan_wrap) begin
      scan_cnt  <= 16'h0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      scan_cnt  <= scan_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_out <= 8'hFF;
      seg_en  <= 8'hFF;
    end else begin
      seg_out <= seg_nxt;
      seg_en  <= en_nxt;
    end
  end

endmodule

// File: tb/tb_tube_display.sv
// Directed bench for tube_display: SCAN_DIV=4 main instance plus a SCAN_DIV=1 instance.
module tb_tube_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tubecs = 1'b0;
  logic        tubewrite = 1'b0;
  logic [1:0]  tubeaddr = 2'b00;
  logic [15:0] tubewdata = 16'h0;
  logic [7:0]  seg_out, seg_en, f_seg_out, f_seg_en;
  logic [31:0] tube_value, f_tube_value;

  int n_checks = 0;
  int n_fail = 0;
  int k = 0;

  logic [7:0] cur_exp [8];
  logic [7:0] cur_mask;

  typedef struct {
    string       name;
    logic        cs;
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [31:0] exp_val;
  } wr_vec_t;

  wr_vec_t wv [5];

  always #5 clk = ~clk;

  tube_display #(.SCAN_DIV(4)) u_dut (
    .clk(clk), .reset(reset), .tubecs(tubecs), .tubewrite(tubewrite),
    .tubeaddr(tubeaddr), .tubewdata(tubewdata),
    .seg_out(seg_out), .seg_en(seg_en), .tube_value(tube_value)
  );

  tube_display #(.SCAN_DIV(1)) u_fast (
    .clk(clk), .reset(reset), .tubecs(tubecs), .tubewrite(tubewrite),
    .tubeaddr(tubeaddr), .tubewdata(tubewdata),
    .seg_out(f_seg_out), .seg_en(f_seg_en), .tube_value(f_tube_value)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (k=%0d): got %h, expected %h", name, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  function automatic logic [7:0] en_for(input int d);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << d[2:0]);
  endfunction

  // Each tick k shows the digit selected after edge k-1 (4 edges per slot).
  task automatic scan_check(input int cycles);
    int d;
    for (int i = 0; i < cycles; i++) begin
      tick();
      d = ((k - 1) / 4) % 8;
      if (cur_mask[d]) begin
        chk("blank_en", {24'h0, seg_en}, 32'hFF);
        chk("blank_seg", {24'h0, seg_out}, 32'hFF);
      end else begin
        chk("scan_en", {24'h0, seg_en}, {24'h0, en_for(d)});
        chk("scan_seg", {24'h0, seg_out}, {24'h0, cur_exp[d]});
      end
    end
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [15:0] data);
    tubecs = 1'b1;
    tubewrite = 1'b1;
    tubeaddr = addr;
    tubewdata = data;
    tick();
    tubecs = 1'b0;
    tubewrite = 1'b0;
  endtask

  initial begin
    wv[0] = '{"wr_lo",          1'b1, 1'b1, 2'b00, 16'h89AB, 32'h0000_89AB};
    wv[1] = '{"wr_hi",          1'b1, 1'b1, 2'b01, 16'h1234, 32'h1234_89AB};
    wv[2] = '{"cs_low_lo",      1'b0, 1'b1, 2'b00, 16'hFFFF, 32'h1234_89AB};
    wv[3] = '{"cs_low_hi",      1'b0, 1'b1, 2'b01, 16'hFFFF, 32'h1234_89AB};
    wv[4] = '{"we_low",         1'b1, 1'b0, 2'b00, 16'hFFFF, 32'h1234_89AB};

    #1 reset = 1'b0;
    #2;
    chk("rst_seg_en", {24'h0, seg_en}, 32'hFF);
    chk("rst_seg_out", {24'h0, seg_out}, 32'hFF);
    chk("rst_value", tube_value, 32'h0);
    chk("rst_fast_en", {24'h0, f_seg_en}, 32'hFF);
    @(posedge clk);
    #1;
    chk("rst_hold_en", {24'h0, seg_en}, 32'hFF);
    reset = 1'b1;
    k = 0;

    // Idle scan, including the 7F -> FE wrap; fast instance steps every edge.
    for (int i = 0; i < 36; i++) begin
      tick();
      chk("idle_en", {24'h0, seg_en}, {24'h0, en_for(((k - 1) / 4) % 8)});
      chk("idle_seg", {24'h0, seg_out}, 32'hC0);
      chk("fast_en", {24'h0, f_seg_en}, {24'h0, en_for((k - 1) % 8)});
      chk("fast_seg", {24'h0, f_seg_out}, 32'hC0);
    end

    for (int i = 0; i < 5; i++) begin
      tubecs = wv[i].cs;
      tubewrite = wv[i].we;
      tubeaddr = wv[i].addr;
      tubewdata = wv[i].wdata;
      tick();
      tubecs = 1'b0;
      tubewrite = 1'b0;
      chk(wv[i].name, tube_value, wv[i].exp_val);
    end

    cur_exp = '{8'h83, 8'h88, 8'h90, 8'h80, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    cur_mask = 8'h00;
    scan_check(32);

    do_write(2'b10, 16'h00F0);
    chk("mask_wr_value", tube_value, 32'h1234_89AB);
    cur_mask = 8'hF0;
    scan_check(32);

    do_write(2'b11, 16'hFFFF);
    chk("rsvd_wr_value", tube_value, 32'h1234_89AB);
    scan_check(32);

    do_write(2'b10, 16'h0000);
    cur_mask = 8'h00;
    for (int i = 0; i < 40 && ((k + 1) % 32) != 0; i++) tick();
    chk("wrap_align", (k + 1) % 32, 0);
    do_write(2'b00, 16'h000F);
    chk("wrap_edge_en", {24'h0, seg_en}, 32'h7F);
    chk("wrap_edge_seg", {24'h0, seg_out}, 32'hF9);
    chk("wrap_value", tube_value, 32'h1234_000F);
    tick();
    chk("after_wrap_en", {24'h0, seg_en}, 32'hFE);
    chk("after_wrap_seg", {24'h0, seg_out}, 32'h8E);

    for (int i = 0; i < 40 && (((k - 1) / 4) % 8) != 5; i++) tick();
    chk("pre_rst_digit5", {24'h0, seg_en}, 32'hDF);
    tubecs = 1'b1;
    tubewrite = 1'b1;
    tubeaddr = 2'b00;
    tubewdata = 16'h5555;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_en", {24'h0, seg_en}, 32'hFF);
    chk("async_rst_seg", {24'h0, seg_out}, 32'hFF);
    chk("async_rst_value", tube_value, 32'h0);
    chk("async_rst_fast", f_tube_value, 32'h0);
    @(posedge clk);
    #1;
    tubecs = 1'b0;
    tubewrite = 1'b0;
    chk("rst_write_discard", tube_value, 32'h0);
    reset = 1'b1;
    k = 0;
    tick();
    chk("restart_en", {24'h0, seg_en}, 32'hFE);
    chk("restart_seg", {24'h0, seg_out}, 32'hC0);
    chk("restart_value", tube_value, 32'h0);
    chk("restart_fast_en", {24'h0, f_seg_en}, 32'hFE);
    tick();
    chk("restart_fast_en2", {24'h0, f_seg_en}, 32'hFD);
    tick();
    tick();
    chk("restart_en4", {24'h0, seg_en}, 32'hFE);
    tick();
    chk("restart_en5", {24'h0, seg_en}, 32'hFD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
